// File: rtl/axi_pkg.sv
// Shared AXI encodings plus the state types of the burst splitter.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    W_BRESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_e;

  // Worst response wins, relying on the encoding order DECERR > SLVERR > OKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] beat);
    return (beat > acc) ? beat : acc;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] incr;

  // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    step        = ADDR_W'(1) << size_i;
    span        = ADDR_W'(len_i) + ADDR_W'(1);
    mask        = (span << size_i) - ADDR_W'(1);
    incr        = addr_i + step;
    next_addr_o = incr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~mask) | (incr & mask);
      default:     next_addr_o = incr;  // INCR and the reserved encoding
    endcase
  end

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits AXI4 bursts into single-beat transactions toward the CLINT,
// merging write responses and regenerating rlast on the way back.
module axi_burst_splitter
  import axi_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // upstream write
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [AXI_ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic [2:0]              s_awprot,
  input  logic [AXI_ID_W-1:0]     s_awid,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic                    s_wlast,
  input  logic [AXI_DATA_W-1:0]   s_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [AXI_ID_W-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  // upstream read
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [AXI_ADDR_W-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic [2:0]              s_arprot,
  input  logic [AXI_ID_W-1:0]     s_arid,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [AXI_ID_W-1:0]     s_rid,
  output logic [1:0]              s_rresp,
  output logic [AXI_DATA_W-1:0]   s_rdata,
  output logic                    s_rlast,
  // downstream write
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [AXI_ADDR_W-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [2:0]              m_awprot,
  output logic [AXI_ID_W-1:0]     m_awid,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic                    m_wlast,
  output logic [AXI_DATA_W-1:0]   m_wdata,
  output logic [AXI_DATA_W/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [AXI_ID_W-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  // downstream read
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [AXI_ADDR_W-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic [2:0]              m_arprot,
  output logic [AXI_ID_W-1:0]     m_arid,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [AXI_ID_W-1:0]     m_rid,
  input  logic [1:0]              m_rresp,
  input  logic [AXI_DATA_W-1:0]   m_rdata,
  input  logic                    m_rlast
);

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [2:0]            prot;
    logic [AXI_ID_W-1:0]   id;
  } req_t;

  w_state_e   w_state_q, w_state_d;
  req_t       aw_q, aw_d;
  logic [7:0] w_cnt_q, w_cnt_d;
  logic [1:0] bresp_q, bresp_d;
  logic       s_awready_q, s_awready_d;
  logic [AXI_ADDR_W-1:0] aw_next_addr;

  r_state_e   r_state_q, r_state_d;
  req_t       ar_q, ar_d;
  logic [7:0] r_cnt_q, r_cnt_d;
  logic       s_arready_q, s_arready_d;
  logic [AXI_ADDR_W-1:0] ar_next_addr;

  // Sideband the CLINT never needs: wlast/rlast are regenerated, ids are captured.
  logic unused;
  assign unused = ^{s_wlast, m_bid, m_rid, m_rlast};

  axi_burst_addr_gen #(.ADDR_W(AXI_ADDR_W)) u_aw_addr (
    .addr_i     (aw_q.addr),
    .len_i      (aw_q.len),
    .size_i     (aw_q.size),
    .burst_i    (aw_q.burst),
    .next_addr_o(aw_next_addr)
  );

  axi_burst_addr_gen #(.ADDR_W(AXI_ADDR_W)) u_ar_addr (
    .addr_i     (ar_q.addr),
    .len_i      (ar_q.len),
    .size_i     (ar_q.size),
    .burst_i    (ar_q.burst),
    .next_addr_o(ar_next_addr)
  );

  // ---------------- write path ----------------
  always_comb begin
    w_state_d = w_state_q;
    aw_d      = aw_q;
    w_cnt_d   = w_cnt_q;
    bresp_d   = bresp_q;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    s_wready  = 1'b0;
    m_bready  = 1'b0;
    s_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_awvalid && s_awready_q) begin
          aw_d.addr  = s_awaddr;
          aw_d.len   = s_awlen;
          aw_d.size  = s_awsize;
          aw_d.burst = s_awburst;
          aw_d.prot  = s_awprot;
          aw_d.id    = s_awid;
          w_cnt_d    = '0;
          bresp_d    = RESP_OKAY;
          w_state_d  = W_ADDR;
        end
      end
      W_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) w_state_d = W_DATA;
      end
      W_DATA: begin
        m_wvalid = s_wvalid;
        s_wready = m_wready;
        if (s_wvalid && m_wready) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          bresp_d = resp_merge(bresp_q, m_bresp);
          if (w_cnt_q == aw_q.len) begin
            w_state_d = W_BRESP;
          end else begin
            w_cnt_d   = w_cnt_q + 8'd1;
            aw_d.addr = aw_next_addr;
            w_state_d = W_ADDR;
          end
        end
      end
      W_BRESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    s_awready_d = (w_state_d == W_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      aw_q        <= '0;
      w_cnt_q     <= '0;
      bresp_q     <= RESP_OKAY;
      s_awready_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      aw_q        <= aw_d;
      w_cnt_q     <= w_cnt_d;
      bresp_q     <= bresp_d;
      s_awready_q <= s_awready_d;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    r_state_d = r_state_q;
    ar_d      = ar_q;
    r_cnt_d   = r_cnt_q;
    m_arvalid = 1'b0;
    s_rvalid  = 1'b0;
    m_rready  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid && s_arready_q) begin
          ar_d.addr  = s_araddr;
          ar_d.len   = s_arlen;
          ar_d.size  = s_arsize;
          ar_d.burst = s_arburst;
          ar_d.prot  = s_arprot;
          ar_d.id    = s_arid;
          r_cnt_d    = '0;
          r_state_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        s_rvalid = m_rvalid;
        m_rready = s_rready;
        if (m_rvalid && s_rready) begin
          if (r_cnt_q == ar_q.len) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d   = r_cnt_q + 8'd1;
            ar_d.addr = ar_next_addr;
            r_state_d = R_ADDR;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    s_arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q   <= R_IDLE;
      ar_q        <= '0;
      r_cnt_q     <= '0;
      s_arready_q <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      ar_q        <= ar_d;
      r_cnt_q     <= r_cnt_d;
      s_arready_q <= s_arready_d;
    end
  end

  // ---------------- fixed and pass-through fields ----------------
  assign s_awready = s_awready_q;
  assign s_arready = s_arready_q;

  assign m_awaddr  = aw_q.addr;
  assign m_awlen   = 8'd0;
  assign m_awsize  = aw_q.size;
  assign m_awburst = BURST_INCR;
  assign m_awprot  = aw_q.prot;
  assign m_awid    = aw_q.id;
  assign m_wlast   = 1'b1;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign s_bid     = aw_q.id;
  assign s_bresp   = bresp_q;

  assign m_araddr  = ar_q.addr;
  assign m_arlen   = 8'd0;
  assign m_arsize  = ar_q.size;
  assign m_arburst = BURST_INCR;
  assign m_arprot  = ar_q.prot;
  assign m_arid    = ar_q.id;
  assign s_rid     = ar_q.id;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = (r_cnt_q == ar_q.len);

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Randomized bench for axi_burst_splitter: upstream master, downstream CLINT model,
// and an address/response reference computed from the burst rules directly.
`timescale 1ns/1ps
module tb_axi_burst_splitter;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic [2:0]  s_awprot;
  logic [7:0]  s_awid;
  logic        s_wvalid, s_wready, s_wlast;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [7:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [2:0]  s_arprot;
  logic [7:0]  s_arid;
  logic        s_rvalid, s_rready;
  logic [7:0]  s_rid;
  logic [1:0]  s_rresp;
  logic [31:0] s_rdata;
  logic        s_rlast;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [2:0]  m_awprot;
  logic [7:0]  m_awid;
  logic        m_wvalid, m_wready, m_wlast;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [7:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [2:0]  m_arprot;
  logic [7:0]  m_arid;
  logic        m_rvalid, m_rready;
  logic [7:0]  m_rid;
  logic [1:0]  m_rresp;
  logic [31:0] m_rdata;
  logic        m_rlast;

  always #5 clk = ~clk;

  axi_burst_splitter #(.AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awprot(s_awprot), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arprot(s_arprot), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rresp(s_rresp),
    .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awprot(m_awprot), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arprot(m_arprot), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rresp(m_rresp),
    .m_rdata(m_rdata), .m_rlast(m_rlast)
  );

  int n_vec = 0;
  int n_err = 0;
  bit stall = 1'b0;

  logic [31:0] aw_log[$], w_log[$], ar_log[$], ar_pend[$];
  logic [1:0]  bresp_plan[$], rresp_plan[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat i address from the burst definition: offset arithmetic, not iteration.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input logic [1:0] burst, input int i);
    longint unsigned step, total, base, aa;
    step  = 64'd1 << size;
    total = longint'(len + 1) * step;
    aa    = {32'd0, a};
    case (burst)
      2'b00:   return a;
      2'b10: begin
        base = (aa / total) * total;
        return 32'(base + ((aa - base) + longint'(i) * step) % total);
      end
      default: return 32'(aa + longint'(i) * step);
    endcase
  endfunction

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return a ^ 32'hC3C3_A5A5;
  endfunction

  function automatic logic [1:0] pick_resp(input bit randomize);
    if (!randomize || $urandom_range(0, 3) != 0) return 2'b00;
    return 2'($urandom_range(1, 3));
  endfunction

  // ---------------- downstream write slave ----------------
  int b_owed = 0;
  bit b_hs = 1'b0;
  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; b_owed = 0; b_hs = 1'b0;
        continue;
      end
      if (b_hs) begin m_bvalid = 1'b0; b_hs = 1'b0; end
      if (!m_bvalid && b_owed > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
        m_bvalid = 1'b1;
        m_bresp  = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
        b_owed--;
      end
      m_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_awvalid && m_awready) begin
        aw_log.push_back(m_awaddr);
        check("m_awlen", m_awlen, 0);
        check("m_awburst", m_awburst, 1);
      end
      if (m_wvalid && m_wready) begin
        w_log.push_back(m_wdata);
        check("m_wlast", m_wlast, 1);
        b_owed++;
      end
      if (m_bvalid && m_bready) b_hs = 1'b1;
    end
  end

  // ---------------- downstream read slave ----------------
  bit r_hs = 1'b0;
  initial begin
    logic [31:0] a;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0; m_rid = 8'h00; m_rlast = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_arready = 1'b0; m_rvalid = 1'b0; r_hs = 1'b0; ar_pend.delete();
        continue;
      end
      if (r_hs) begin m_rvalid = 1'b0; r_hs = 1'b0; end
      if (!m_rvalid && ar_pend.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
        a        = ar_pend.pop_front();
        m_rvalid = 1'b1;
        m_rdata  = rdata_fn(a);
        m_rresp  = (rresp_plan.size() > 0) ? rresp_plan.pop_front() : 2'b00;
      end
      m_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_arvalid && m_arready) begin
        ar_log.push_back(m_araddr);
        ar_pend.push_back(m_araddr);
        check("m_arlen", m_arlen, 0);
        check("m_arburst", m_arburst, 1);
      end
      if (m_rvalid && m_rready) r_hs = 1'b1;
    end
  end

  // ---------------- valid-stability monitor ----------------
  logic        p_rst = 1'b1;
  logic        p_awv = 1'b0, p_awr = 1'b0, p_arv = 1'b0, p_arr = 1'b0, p_bv = 1'b0, p_br = 1'b0;
  logic [31:0] p_awa, p_ara;
  logic [1:0]  p_bresp;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !p_rst) begin
        if (p_awv && !p_awr) begin
          check("aw_hold", m_awvalid, 1);
          check("aw_hold_addr", m_awaddr, p_awa);
        end
        if (p_arv && !p_arr) begin
          check("ar_hold", m_arvalid, 1);
          check("ar_hold_addr", m_araddr, p_ara);
        end
        if (p_bv && !p_br) begin
          check("b_hold", s_bvalid, 1);
          check("b_hold_resp", s_bresp, p_bresp);
        end
      end
      p_awv = m_awvalid; p_awr = m_awready; p_awa = m_awaddr;
      p_arv = m_arvalid; p_arr = m_arready; p_ara = m_araddr;
      p_bv  = s_bvalid;  p_br  = s_bready;  p_bresp = s_bresp;
      p_rst = rst;
    end
  end

  // ---------------- upstream write burst ----------------
  // err_beat >= 0 places err_code on that beat; -2 draws random responses.
  task automatic do_write(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst,
                          input logic [7:0] id, input int err_beat, input logic [1:0] err_code);
    logic [31:0] data[$];
    logic [1:0]  r;
    logic [1:0]  exp_resp = 2'b00;
    logic [1:0]  got_resp = 2'b00;
    logic [7:0]  got_id = 8'h00;
    bit ok;
    int extra = 0;
    aw_log.delete(); w_log.delete(); bresp_plan.delete();
    for (int i = 0; i <= len; i++) begin
      data.push_back($urandom);
      if (err_beat == -2) r = pick_resp(1'b1);
      else r = (i == err_beat) ? err_code : 2'b00;
      bresp_plan.push_back(r);
      if (r > exp_resp) exp_resp = r;
    end
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = addr; s_awlen = 8'(len); s_awsize = 3'(size);
    s_awburst = burst; s_awprot = 3'(id); s_awid = id;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (s_awready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("aw_accept", ok, 1);
    @(negedge clk);
    s_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (stall) repeat ($urandom_range(0, 1)) @(negedge clk);
      s_wvalid = 1'b1; s_wdata = data[i]; s_wstrb = 4'hF; s_wlast = (i == len);
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        #1;
        if (s_wready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      @(negedge clk);
      s_wvalid = 1'b0;
      if (!ok) begin check("w_accept", 0, 1); break; end
    end
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      s_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (s_bvalid && s_bready) begin ok = 1'b1; got_resp = s_bresp; got_id = s_bid; end
      @(negedge clk);
      if (ok) break;
    end
    check("b_seen", ok, 1);
    s_bready = 1'b1;
    repeat (6) begin
      #1;
      if (s_bvalid) extra++;
      @(negedge clk);
    end
    s_bready = 1'b0;
    check("b_extra", extra, 0);
    check("bresp", got_resp, exp_resp);
    check("bid", got_id, id);
    check("aw_count", aw_log.size(), len + 1);
    check("w_count", w_log.size(), len + 1);
    for (int i = 0; i <= len && i < aw_log.size(); i++)
      check($sformatf("aw_addr[%0d]", i), aw_log[i], beat_addr(addr, len, size, burst, i));
    for (int i = 0; i <= len && i < w_log.size(); i++)
      check($sformatf("w_data[%0d]", i), w_log[i], data[i]);
  endtask

  // ---------------- upstream read burst ----------------
  task automatic do_read(input logic [31:0] addr, input int len, input int size, input logic [1:0] burst,
                         input logic [7:0] id, input bit rand_resp);
    logic [1:0]  plan[$];
    logic [31:0] got_d[$];
    logic [1:0]  got_r[$];
    logic [7:0]  got_i[$];
    logic        got_l[$];
    bit ok;
    int beats = 0;
    int extra = 0;
    ar_log.delete(); rresp_plan.delete();
    for (int i = 0; i <= len; i++) begin
      plan.push_back(pick_resp(rand_resp));
      rresp_plan.push_back(plan[i]);
    end
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = addr; s_arlen = 8'(len); s_arsize = 3'(size);
    s_arburst = burst; s_arprot = 3'(id); s_arid = id;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (s_arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("ar_accept", ok, 1);
    @(negedge clk);
    s_arvalid = 1'b0;
    for (int t = 0; t < 4000 && beats <= len; t++) begin
      s_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (s_rvalid && s_rready) begin
        got_d.push_back(s_rdata); got_r.push_back(s_rresp);
        got_i.push_back(s_rid);   got_l.push_back(s_rlast);
        beats++;
      end
      @(negedge clk);
    end
    s_rready = 1'b1;
    repeat (6) begin
      #1;
      if (s_rvalid) extra++;
      @(negedge clk);
    end
    s_rready = 1'b0;
    check("r_count", beats, len + 1);
    check("r_extra", extra, 0);
    check("ar_count", ar_log.size(), len + 1);
    for (int i = 0; i <= len && i < ar_log.size(); i++)
      check($sformatf("ar_addr[%0d]", i), ar_log[i], beat_addr(addr, len, size, burst, i));
    for (int i = 0; i < beats; i++) begin
      check($sformatf("rdata[%0d]", i), got_d[i], rdata_fn(beat_addr(addr, len, size, burst, i)));
      check($sformatf("rresp[%0d]", i), got_r[i], plan[i]);
      check($sformatf("rid[%0d]", i), got_i[i], id);
      check($sformatf("rlast[%0d]", i), got_l[i], (i == len));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int len;
    logic [1:0] bw, br;
    rst = 1'b1;
    s_awvalid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0; s_awprot = 0; s_awid = 0;
    s_wvalid = 0; s_wlast = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_arprot = 0; s_arid = 0;
    s_rready = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_s_bvalid", s_bvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("awready_before_edge", s_awready, 0);
    @(negedge clk);
    #1;
    check("awready_after_edge", s_awready, 1);
    check("arready_after_edge", s_arready, 1);

    do_write(32'h0200_4000, 3, 2, BURST_INCR,  8'h5A, -1, 2'b00);
    do_read (32'h0200_BFF8, 3, 2, BURST_WRAP,  8'h3C, 1'b0);
    do_write(32'h0200_0000, 1, 2, BURST_FIXED, 8'h11, -1, 2'b00);
    do_write(32'h0200_1000, 3, 2, BURST_INCR,  8'h22, 1, RESP_SLVERR);
    do_write(32'h0200_2000, 3, 2, BURST_INCR,  8'h23, 2, RESP_DECERR);
    do_write(32'h0200_3000, 0, 2, BURST_INCR,  8'h24, -1, 2'b00);
    do_read (32'h0200_3000, 0, 2, BURST_INCR,  8'h25, 1'b1);
    do_write(32'h0200_5000, 2, 2, BURST_RSVD,  8'h26, -1, 2'b00);
    do_read (32'h0200_6000, 255, 2, BURST_INCR, 8'h27, 1'b0);
    do_write(32'h0200_7000, 255, 0, BURST_INCR, 8'h28, 200, RESP_SLVERR);

    stall = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bw  = 2'($urandom_range(0, 3));
      br  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 15);
      fork
        do_write($urandom, (bw == 2'b10) ? (2 << $urandom_range(0, 3)) - 1 : len,
                 $urandom_range(0, 2), bw, 8'($urandom), -2, 2'b00);
        do_read($urandom, (br == 2'b10) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15),
                $urandom_range(0, 2), br, 8'($urandom), 1'b1);
      join
    end
    stall = 1'b0;

    // Reset during the second beat of a len=3 write.
    aw_log.delete(); w_log.delete(); bresp_plan.delete();
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 32'h0200_8000; s_awlen = 8'd3; s_awsize = 3'd2;
    s_awburst = BURST_INCR; s_awid = 8'h77;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (s_awready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_test_aw", ok, 1);
    @(negedge clk);
    s_awvalid = 1'b0;
    s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (aw_log.size() >= 2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_test_beat2", ok, 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_m_awvalid", m_awvalid, 0);
    check("midrst_m_wvalid", m_wvalid, 0);
    check("midrst_s_wready", s_wready, 0);
    check("midrst_m_bready", m_bready, 0);
    check("midrst_s_bvalid", s_bvalid, 0);
    check("midrst_s_awready", s_awready, 0);
    check("midrst_s_bresp", s_bresp, 0);
    s_wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("midrst_hold_awvalid", m_awvalid, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_awready_pre", s_awready, 0);
    @(negedge clk);
    #1;
    check("rel_awready_post", s_awready, 1);
    check("rel_arready_post", s_arready, 1);
    do_write(32'h0200_9000, 0, 2, BURST_INCR, 8'h78, -1, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation exceeded time budget");
  end

endmodule
